// File: rtl/rs_dec_pkg.sv
// Shared GF(256) definitions for the C1 Reed-Solomon decoder back end (N=32, t=2).
// Field uses primitive polynomial 0x11D with alpha = 0x02.
package rs_dec_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int         N       = 32;
    localparam int         POS_W   = 5;

    localparam logic [POS_W-1:0] INV_LAST    = POS_W'(6);
    localparam logic [POS_W-1:0] SEARCH_LAST = POS_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INV    = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // Halving: an odd value first has the polynomial folded in so the shift is exact.
    function automatic logic [7:0] mul_alpha_inv(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? GF_POLY[8:1] : 8'h00);
    endfunction

    function automatic logic [7:0] mul_alpha_inv2(input logic [7:0] x);
        return mul_alpha_inv(mul_alpha_inv(x));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = mul_alpha(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational 8x8 multiplier over GF(256), polynomial 0x11D.
module gf256_mul
    import rs_dec_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/rs_dec_chien_forney.sv
// Chien search and Forney magnitude evaluation for the t=2, N=32 C1 Reed-Solomon decoder.
// Takes Lambda/Omega once per codeword and emits one registered pulse per located error.
module rs_dec_chien_forney
    import rs_dec_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_resb,
    input  logic             i_loc_sync,
    input  logic [7:0]       i_gl0,
    input  logic [7:0]       i_gl1,
    input  logic [7:0]       i_gl2,
    input  logic [7:0]       i_gg0,
    input  logic [7:0]       i_gg1,
    output logic             o_err_valid,
    output logic [POS_W-1:0] o_err_pos,
    output logic [7:0]       o_err_val,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fail,
    output logic             o_overrun
);

    // state  | meaning
    // IDLE   | waiting for i_loc_sync
    // INV    | square-and-multiply producing gl1^-1 (7 cycles)
    // SEARCH | evaluate Lambda at alpha^-j for j = 0..31 (32 cycles)
    // DONE   | report o_done / o_fail, then back to IDLE

    state_t           state;
    state_t           state_nxt;
    logic [POS_W-1:0] cnt;
    logic [7:0]       gl0_q;
    logic [7:0]       gl1_q;
    logic [7:0]       gl2_q;
    logic [7:0]       gg0_q;
    logic [7:0]       r_q;
    logic [7:0]       x_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [7:0]       c_q;
    logic [1:0]       root_cnt;
    logic [1:0]       degree;
    logic             accept;
    logic             hit;
    logic             fail_cond;
    logic [7:0]       sq;
    logic [7:0]       inv_b;
    logic [7:0]       inv_step;
    logic [7:0]       omega_val;
    logic [7:0]       mag_pre;
    logic [7:0]       mag;

    assign accept    = (state == IDLE) && i_loc_sync;
    assign sq        = gf_mul(r_q, r_q);
    // Exponent 254 = 0b1111_1110: six multiply steps, then a final square only.
    assign inv_b     = (cnt == '0) ? 8'h01 : gl1_q;
    assign hit       = (gl0_q ^ a_q ^ b_q) == 8'h00;
    assign omega_val = gg0_q ^ c_q;
    assign degree    = (gl2_q != 8'h00) ? 2'd2 : ((gl1_q != 8'h00) ? 2'd1 : 2'd0);
    assign fail_cond = (root_cnt != degree) || (gl0_q == 8'h00) ||
                       ((gl1_q == 8'h00) && (gl2_q != 8'h00));

    gf256_mul u_inv_mul  (.a(sq),      .b(inv_b),     .p(inv_step));
    gf256_mul u_mag_mul0 (.a(x_q),     .b(omega_val), .p(mag_pre));
    gf256_mul u_mag_mul1 (.a(mag_pre), .b(r_q),       .p(mag));

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_loc_sync) state_nxt = INV;
            INV:     if (cnt == '0)  state_nxt = SEARCH;
            SEARCH:  if (cnt == '0)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            cnt         <= '0;
            gl0_q       <= '0;
            gl1_q       <= '0;
            gl2_q       <= '0;
            gg0_q       <= '0;
            r_q         <= '0;
            x_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            root_cnt    <= '0;
            o_err_valid <= 1'b0;
            o_err_pos   <= '0;
            o_err_val   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_err_valid <= 1'b0;
            o_done      <= 1'b0;
            o_fail      <= 1'b0;
            o_overrun   <= i_loc_sync && (state != IDLE);

            if (accept)      o_busy <= 1'b1;
            else if (o_done) o_busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_loc_sync) begin
                        gl0_q    <= i_gl0;
                        gl1_q    <= i_gl1;
                        gl2_q    <= i_gl2;
                        gg0_q    <= i_gg0;
                        r_q      <= i_gl1;
                        x_q      <= 8'h01;
                        a_q      <= i_gl1;
                        b_q      <= i_gl2;
                        c_q      <= i_gg1;
                        root_cnt <= '0;
                        cnt      <= INV_LAST;
                    end
                end
                INV: begin
                    r_q <= inv_step;
                    cnt <= (cnt == '0) ? SEARCH_LAST : cnt - POS_W'(1);
                end
                SEARCH: begin
                    x_q <= mul_alpha(x_q);
                    a_q <= mul_alpha_inv(a_q);
                    b_q <= mul_alpha_inv2(b_q);
                    c_q <= mul_alpha_inv(c_q);
                    cnt <= cnt - POS_W'(1);
                    if (hit) begin
                        o_err_valid <= 1'b1;
                        o_err_pos   <= ~cnt;
                        o_err_val   <= mag;
                        if (root_cnt != 2'd3) root_cnt <= root_cnt + 2'd1;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_fail <= fail_cond;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_dec_chien_forney.sv
// Scoreboard bench for rs_dec_chien_forney: directed corner cases plus randomized codewords,
// with expectations derived from injected error patterns or direct polynomial evaluation.
module tb_rs_dec_chien_forney;

    logic       i_clk      = 1'b0;
    logic       i_resb     = 1'b0;
    logic       i_loc_sync = 1'b0;
    logic [7:0] i_gl0      = 8'h00;
    logic [7:0] i_gl1      = 8'h00;
    logic [7:0] i_gl2      = 8'h00;
    logic [7:0] i_gg0      = 8'h00;
    logic [7:0] i_gg1      = 8'h00;
    logic       o_err_valid;
    logic [4:0] o_err_pos;
    logic [7:0] o_err_val;
    logic       o_busy;
    logic       o_done;
    logic       o_fail;
    logic       o_overrun;

    typedef struct { int cyc; int pos; int val; } err_exp_t;
    typedef struct { int cyc; int fail; } done_exp_t;

    err_exp_t  err_q[$];
    done_exp_t done_q[$];
    int        ovr_q[$];
    err_exp_t  e_m;
    done_exp_t d_m;
    int        o_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_t[0:255];
    int log_t[0:255];

    rs_dec_chien_forney dut (
        .i_clk       (i_clk),
        .i_resb      (i_resb),
        .i_loc_sync  (i_loc_sync),
        .i_gl0       (i_gl0),
        .i_gl1       (i_gl1),
        .i_gl2       (i_gl2),
        .i_gg0       (i_gg0),
        .i_gg1       (i_gg1),
        .o_err_valid (o_err_valid),
        .o_err_pos   (o_err_pos),
        .o_err_val   (o_err_val),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_fail      (o_fail),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic int gpow(input int e);
        return exp_t[((e % 255) + 255) % 255];
    endfunction

    function automatic int ginv(input int a);
        if (a == 0) return 0;
        return exp_t[(255 - log_t[a]) % 255];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_err(input int c, input int pos, input int val);
        err_exp_t e;
        e.cyc = c; e.pos = pos; e.val = val;
        err_q.push_back(e);
    endtask

    task automatic push_done(input int c, input int fail);
        done_exp_t d;
        d.cyc = c; d.fail = fail;
        done_q.push_back(d);
    endtask

    // Direct evaluation of Lambda at every alpha^-j, Forney value, degree/root-count rule.
    task automatic push_model(input int t, input int g0, input int g1, input int g2,
                              input int h0, input int h1);
        int roots;
        int deg;
        int xi;
        int lam;
        int fail;
        roots = 0;
        for (int j = 0; j < 32; j++) begin
            xi  = gpow(-j);
            lam = g0 ^ gmul(g1, xi) ^ gmul(g2, gmul(xi, xi));
            if (lam == 0) begin
                push_err(t + 8 + j, j, gmul(gmul(gpow(j), h0 ^ gmul(h1, xi)), ginv(g1)));
                roots++;
            end
        end
        deg  = (g2 != 0) ? 2 : ((g1 != 0) ? 1 : 0);
        fail = (roots != deg || g0 == 0 || (g1 == 0 && g2 != 0)) ? 1 : 0;
        push_done(t + 40, fail);
    endtask

    // Lambda from error locators, Omega = S(x)*Lambda(x) mod x^2 with S_i = sum e*X^i, i=0,1.
    task automatic errs_coef(input int nerr, input int p1, input int e1, input int p2, input int e2,
                             output int l1, output int l2, output int o0, output int o1);
        int x1, x2, a1, a2, s0, s1;
        x1 = gpow(p1);
        x2 = gpow(p2);
        a1 = (nerr >= 1) ? e1 : 0;
        a2 = (nerr == 2) ? e2 : 0;
        l1 = (nerr == 0) ? 0 : ((nerr == 1) ? x1 : (x1 ^ x2));
        l2 = (nerr == 2) ? gmul(x1, x2) : 0;
        s0 = a1 ^ a2;
        s1 = gmul(a1, x1) ^ gmul(a2, x2);
        o0 = s0;
        o1 = s1 ^ gmul(s0, l1);
    endtask

    task automatic expect_errs(input int t, input int nerr, input int p1, input int e1,
                               input int p2, input int e2);
        if (nerr == 1) begin
            push_err(t + 8 + p1, p1, e1);
        end else if (nerr == 2) begin
            if (p1 < p2) begin
                push_err(t + 8 + p1, p1, e1);
                push_err(t + 8 + p2, p2, e2);
            end else begin
                push_err(t + 8 + p2, p2, e2);
                push_err(t + 8 + p1, p1, e1);
            end
        end
        push_done(t + 40, 0);
    endtask

    task automatic sync_cw(input int g0, input int g1, input int g2, input int h0, input int h1,
                           output int t);
        i_gl0 = g0[7:0]; i_gl1 = g1[7:0]; i_gl2 = g2[7:0];
        i_gg0 = h0[7:0]; i_gg1 = h1[7:0];
        i_loc_sync = 1'b1;
        t = cyc + 1;
        @(negedge i_clk);
        i_loc_sync = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((err_q.size() + done_q.size() + ovr_q.size()) != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_pending", err_q.size() + done_q.size() + ovr_q.size(), 0);
        @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_err_valid"}, o_err_valid, 0);
        check({tag, "_err_pos"},   o_err_pos,   0);
        check({tag, "_err_val"},   o_err_val,   0);
        check({tag, "_busy"},      o_busy,      0);
        check({tag, "_done"},      o_done,      0);
        check({tag, "_fail"},      o_fail,      0);
        check({tag, "_overrun"},   o_overrun,   0);
    endtask

    always @(negedge i_clk) begin
        if (i_resb) begin
            if (o_err_valid === 1'b1) begin
                if (err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL err_unexpected: pulse pos %0d val %0h at cycle %0d with none pending",
                             o_err_pos, o_err_val, cyc);
                end else begin
                    e_m = err_q.pop_front();
                    check("err_cycle", cyc, e_m.cyc);
                    check("err_pos", o_err_pos, e_m.pos);
                    check("err_val", o_err_val, e_m.val);
                end
            end
            if (o_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_unexpected: o_done at cycle %0d with none pending", cyc);
                end else begin
                    d_m = done_q.pop_front();
                    check("done_cycle", cyc, d_m.cyc);
                    check("done_fail", o_fail, d_m.fail);
                    check("done_busy", o_busy, 1);
                end
            end
            if (o_overrun === 1'b1) begin
                if (ovr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL overrun_unexpected: o_overrun at cycle %0d with none pending", cyc);
                end else begin
                    o_m = ovr_q.pop_front();
                    check("overrun_cycle", cyc, o_m);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2, v, sel;
        int l1, l2, o0, o1;
        int nerr, p1, p2, e1, e2;
        int g0, g1, g2, h0, h1;

        v = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if ((v & 'h100) != 0) v = v ^ 'h11D;
        end
        exp_t[255] = 1;
        log_t[0]   = 0;

        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_resb = 1'b1;
        @(negedge i_clk);

        // Degree 0: full run, no pulses, busy framing around o_done
        sync_cw(1, 0, 0, 0, 0, t);
        push_done(t + 40, 0);
        check("busy_after_sync", o_busy, 1);
        wait_drain();
        check("busy_after_done", o_busy, 0);

        // Single error at position 5 (gl1 = alpha^5)
        sync_cw(1, 'h20, 0, 'h5A, 0, t);
        push_err(t + 13, 5, 'h5A);
        push_done(t + 40, 0);
        wait_drain();

        // Two errors: 0x11 at 3, 0xC4 at 30
        errs_coef(2, 3, 'h11, 30, 'hC4, l1, l2, o0, o1);
        sync_cw(1, l1, l2, o0, o1, t);
        expect_errs(t, 2, 3, 'h11, 30, 'hC4);
        wait_drain();

        // gl1 = 0 with gl2 != 0, and gl0 = 0: both uncorrectable
        h0 = $urandom_range(0, 255); h1 = $urandom_range(0, 255);
        sync_cw(1, 0, 7, h0, h1, t);
        push_model(t, 1, 0, 7, h0, h1);
        wait_drain();
        g1 = $urandom_range(0, 255); g2 = $urandom_range(0, 255);
        sync_cw(0, g1, g2, h0, h1, t);
        push_model(t, 0, g1, g2, h0, h1);
        wait_drain();

        // Sync during SEARCH is dropped and flagged
        errs_coef(2, 3, 'h11, 30, 'hC4, l1, l2, o0, o1);
        sync_cw(1, l1, l2, o0, o1, t);
        expect_errs(t, 2, 3, 'h11, 30, 'hC4);
        ovr_q.push_back(t + 10);
        while (cyc < t + 9) @(negedge i_clk);
        i_gl0 = 8'h55; i_gl1 = 8'hAA; i_gl2 = 8'h33; i_gg0 = 8'hCC; i_gg1 = 8'h0F;
        i_loc_sync = 1'b1;
        @(negedge i_clk);
        i_loc_sync = 1'b0;
        wait_drain();

        // Sync in the DONE cycle is dropped; one cycle later (o_done cycle) it is accepted
        errs_coef(1, 7, 'h3C, 0, 0, l1, l2, o0, o1);
        sync_cw(1, l1, l2, o0, o1, t);
        expect_errs(t, 1, 7, 'h3C, 0, 0);
        ovr_q.push_back(t + 40);
        while (cyc < t + 39) @(negedge i_clk);
        i_gl0 = 8'h00; i_gl1 = 8'h12; i_gl2 = 8'h34; i_gg0 = 8'h56; i_gg1 = 8'h78;
        i_loc_sync = 1'b1;
        @(negedge i_clk);
        errs_coef(1, 20, 'h81, 0, 0, l1, l2, o0, o1);
        i_gl0 = 8'h01; i_gl1 = l1[7:0]; i_gl2 = l2[7:0]; i_gg0 = o0[7:0]; i_gg1 = o1[7:0];
        t2 = cyc + 1;
        @(negedge i_clk);
        i_loc_sync = 1'b0;
        expect_errs(t2, 1, 20, 'h81, 0, 0);
        wait_drain();

        // Reset mid-SEARCH: outputs clear at once, no o_done, next codeword is normal
        errs_coef(2, 3, 'h11, 30, 'hC4, l1, l2, o0, o1);
        sync_cw(1, l1, l2, o0, o1, t);
        expect_errs(t, 2, 3, 'h11, 30, 'hC4);
        while (cyc < t + 19) @(negedge i_clk);
        check("pre_reset_pos", o_err_pos, 3);
        i_resb = 1'b0;
        #1;
        check_all_zero("async_reset");
        err_q.delete();
        done_q.delete();
        repeat (2) @(negedge i_clk);
        i_resb = 1'b1;
        repeat (60) @(negedge i_clk);
        sync_cw(1, 'h20, 0, 'h5A, 0, t);
        push_err(t + 13, 5, 'h5A);
        push_done(t + 40, 0);
        wait_drain();

        // Randomized codewords
        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 9);
            nerr = $urandom_range(0, 2);
            p1   = $urandom_range(0, 31);
            p2   = (p1 + 1 + $urandom_range(0, 30)) % 32;
            e1   = $urandom_range(1, 255);
            e2   = $urandom_range(1, 255);
            errs_coef(nerr, p1, e1, p2, e2, l1, l2, o0, o1);
            if (sel < 6) begin
                sync_cw(1, l1, l2, o0, o1, t);
                expect_errs(t, nerr, p1, e1, p2, e2);
            end else if (sel < 8) begin
                h0 = $urandom_range(0, 255); h1 = $urandom_range(0, 255);
                sync_cw(1, l1, l2, h0, h1, t);
                push_model(t, 1, l1, l2, h0, h1);
            end else begin
                g0 = $urandom_range(0, 255); g1 = $urandom_range(0, 255);
                g2 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
                h0 = $urandom_range(0, 255); h1 = $urandom_range(0, 255);
                sync_cw(g0, g1, g2, h0, h1, t);
                push_model(t, g0, g1, g2, h0, h1);
            end
            wait_drain();
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
